reg_scoreboard: RTL and testbench

- Tracks in-flight vector-register writes between issue and writeback in the ASIP control unit. Generates issue stalls for RAW and WAW hazards.
- Consumes the 2-bit register-read selector produced by the control-unit read decoder. It is the write-tracking end of that read-usage interface.
- Sits between the decode stage and the issue/operand-fetch stage. The writeback stage feeds it completion notices.

---
 rtl/ctrl_pkg.sv | 14 +
 rtl/sb_entry.sv | 38 +++
 rtl/reg_scoreboard.sv | 70 +++++++
 tb/tb_reg_scoreboard.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-unit read-selector codes, scoreboard entry states and selector decode helpers
package ctrl_pkg;
  localparam logic [1:0] RSEL_BOTH = 2'b00;
  localparam logic [1:0] RSEL_R2   = 2'b01;
  localparam logic [1:0] RSEL_R3   = 2'b10;
  localparam logic [1:0] RSEL_NONE = 2'b11;
  typedef enum logic {SB_IDLE, SB_PEND} sb_state_t;
  function automatic logic reads_r2(input logic [1:0] rsel);
    return rsel == RSEL_BOTH || rsel == RSEL_R2;
  endfunction
  function automatic logic reads_r3(input logic [1:0] rsel);
    return rsel == RSEL_BOTH || rsel == RSEL_R3;
  endfunction
endpackage

// File: rtl/sb_entry.sv
// sb_entry: pending state and watchdog for one register; tmo is sticky until reset
module sb_entry
  import ctrl_pkg::*;
#(
  parameter int TMO_CYC = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  input  logic flush,
  output logic pend,
  output logic tmo
);
  localparam int CW = $clog2(TMO_CYC + 1);
  sb_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic stay;
  assign stay = state == SB_PEND && state_nx == SB_PEND && !set;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SB_IDLE;
      cnt   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= !stay ? '0 : cnt == CW'(TMO_CYC) ? cnt : cnt + 1'b1;
      tmo   <= tmo | (stay && cnt == CW'(TMO_CYC - 1));
    end
  end
  // a re-set in the same cycle as a writeback keeps the entry pending
  always_comb begin
    state_nx = flush ? SB_IDLE : set ? SB_PEND : clr ? SB_IDLE : state;
  end
  always_comb begin
    pend = state == SB_PEND;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight vector-register writes and stalls issue on RAW/WAW hazards.
// Optional SB_WB_FORWARD_EN: same-cycle writeback bypass for the hazard check.
module reg_scoreboard
  import ctrl_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 4,
  parameter int TMO_CYC = 63,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [1:0]        rsel,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [ADDR_W-1:0] r3_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              iss_accept,
  output logic              stall,
  output logic [NREGS-1:0]  pend_mask,
  output logic              tmo_err,
  output logic [STAT_W-1:0] stall_cnt
);
  localparam int NA = 2 ** ADDR_W;
  logic [NA-1:0] pend_ext, eff;
  logic [NREGS-1:0] set_v, clr_v, tmo_v;
  logic raw2, raw3, waw;
`ifdef SB_WB_FORWARD_EN
  logic [NA-1:0] wb_hot;
`endif
  // unused address space above NREGS stays zero so it never reads as pending
  always_comb begin
    pend_ext = '0;
    pend_ext[NREGS-1:0] = pend_mask;
`ifdef SB_WB_FORWARD_EN
    wb_hot = '0;
    wb_hot[wb_addr] = wb_valid;
    eff = pend_ext & ~wb_hot;
`else
    eff = pend_ext;
`endif
    raw2 = reads_r2(rsel) && eff[r2_addr];
    raw3 = reads_r3(rsel) && eff[r3_addr];
    waw = wr_req && eff[rd_addr];
    stall = iss_valid && (raw2 || raw3 || waw);
    iss_accept = iss_valid && !stall;
  end
  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    assign set_v[i] = iss_accept && wr_req && rd_addr == ADDR_W'(i);
    assign clr_v[i] = wb_valid && wb_addr == ADDR_W'(i);
    sb_entry #(.TMO_CYC(TMO_CYC)) u_ent (
      .clk  (clk),
      .rst_n(rst_n),
      .set  (set_v[i]),
      .clr  (clr_v[i]),
      .flush(flush),
      .pend (pend_mask[i]),
      .tmo  (tmo_v[i])
    );
  end
  assign tmo_err = |tmo_v;
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized checks of reg_scoreboard against a behavioural model
module tb_reg_scoreboard;
  import ctrl_pkg::*;
  localparam int NREGS = 16, ADDR_W = 4, TMO = 63, SW = 16;
`ifdef SB_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush, iss_valid, wr_req, wb_valid;
  logic [1:0] rsel;
  logic [ADDR_W-1:0] r2_addr, r3_addr, rd_addr, wb_addr;
  logic iss_accept, stall, tmo_err;
  logic [NREGS-1:0] pend_mask;
  logic [SW-1:0] stall_cnt;
  int n_cmp = 0, n_bad = 0;
  bit mp[NREGS];
  int age[NREGS];
  bit mtmo;
  int mcnt;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .iss_valid(iss_valid), .rsel(rsel),
    .r2_addr(r2_addr), .r3_addr(r3_addr), .wr_req(wr_req), .rd_addr(rd_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .iss_accept(iss_accept), .stall(stall),
    .pend_mask(pend_mask), .tmo_err(tmo_err), .stall_cnt(stall_cnt)
  );

  function automatic bit busy(input logic [ADDR_W-1:0] a);
    return int'(a) < NREGS && mp[a] && !(FWD && wb_valid && wb_addr == a);
  endfunction
  function automatic bit mstall();
    bit h;
    h = (rsel inside {RSEL_BOTH, RSEL_R2}) && busy(r2_addr);
    h = h || ((rsel inside {RSEL_BOTH, RSEL_R3}) && busy(r3_addr));
    h = h || (wr_req && busy(rd_addr));
    return iss_valid && h;
  endfunction
  function automatic logic [NREGS-1:0] mmask();
    logic [NREGS-1:0] m;
    for (int r = 0; r < NREGS; r++) m[r] = mp[r];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit s, acc;
    #3;
    s = mstall();
    acc = iss_valid && !s;
    chk("stall", stall, s);
    chk("iss_accept", iss_accept, acc);
    chk("pend_mask", pend_mask, mmask());
    chk("tmo_err", tmo_err, mtmo);
    chk("stall_cnt", stall_cnt, mcnt);
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin mp[r] = 0; age[r] = 0; end
      mtmo = 0;
      mcnt = 0;
    end else begin
      if (s && mcnt < 65535) mcnt++;
      for (int r = 0; r < NREGS; r++) begin
        if (flush) begin mp[r] = 0; age[r] = 0; end
        else if (acc && wr_req && int'(rd_addr) == r) begin mp[r] = 1; age[r] = 0; end
        else if (wb_valid && int'(wb_addr) == r) begin mp[r] = 0; age[r] = 0; end
        else if (mp[r]) begin
          age[r]++;
          if (age[r] >= TMO) mtmo = 1;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input int a2, input int a3,
                       input bit w, input int rd, input bit wv, input int wa);
    iss_valid = v; rsel = s; r2_addr = ADDR_W'(a2); r3_addr = ADDR_W'(a3);
    wr_req = w; rd_addr = ADDR_W'(rd); wb_valid = wv; wb_addr = ADDR_W'(wa);
  endtask

  initial begin
    rst_n = 0; flush = 0;
    drive(0, RSEL_NONE, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("reset_pend", pend_mask, 0);
    chk("reset_tmo", tmo_err, 0);
    chk("reset_cnt", stall_cnt, 0);
    // first write to R7
    drive(1, RSEL_BOTH, 3, 5, 1, 7, 0, 0);
    #1 chk("t1_accept", iss_accept, 1);
    cyc();
    chk("t1_mask", pend_mask, 16'h0080);
    // RAW on R7 until writeback
    drive(1, RSEL_R2, 7, 0, 0, 0, 0, 0);
    #1 chk("t2_stall", stall, 1);
    cyc(); cyc();
    drive(1, RSEL_R2, 7, 0, 0, 0, 1, 7);
    #1 chk("t2_wb_cycle", iss_accept, FWD);
    cyc();
    drive(1, RSEL_R2, 7, 0, 0, 0, 0, 0);
    #1 chk("t2_after_wb", iss_accept, 1);
    chk("t2_mask", pend_mask, 0);
    cyc();
    // selector variants against pending R7
    drive(1, RSEL_NONE, 0, 0, 1, 7, 0, 0);
    cyc();
    drive(1, RSEL_NONE, 7, 7, 0, 0, 0, 0);
    #1 chk("t3_none", stall, 0);
    cyc();
    drive(1, RSEL_R3, 0, 7, 0, 0, 0, 0);
    #1 chk("t3_r3", stall, 1);
    cyc();
    drive(1, RSEL_R2, 7, 0, 0, 0, 0, 0);
    #1 chk("t3_r2", stall, 1);
    cyc();
    // write and writeback of R4 in the same cycle
    drive(1, RSEL_NONE, 0, 0, 1, 4, 1, 4);
    cyc();
    chk("t4_setwins", pend_mask[4], 1);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15));
      flush = $urandom_range(0, 63) == 0;
      cyc();
    end
    flush = 0;
    rst_n = 0;
    drive(0, RSEL_NONE, 0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1;
    // watchdog and stall-counter saturation on R2
    drive(1, RSEL_NONE, 0, 0, 1, 2, 0, 0);
    cyc();
    drive(1, RSEL_R2, 2, 0, 0, 0, 0, 0);
    repeat (62) cyc();
    chk("tmo_before", tmo_err, 0);
    cyc();
    chk("tmo_reached", tmo_err, 1);
    repeat (70000 - 63) cyc();
    chk("cnt_sat", stall_cnt, 16'hFFFF);
    repeat (5) cyc();
    chk("cnt_held", stall_cnt, 16'hFFFF);
    flush = 1;
    cyc();
    flush = 0;
    chk("flush_mask", pend_mask, 0);
    chk("flush_tmo", tmo_err, 1);
    chk("flush_cnt", stall_cnt, 16'hFFFF);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("rst_tmo", tmo_err, 0);
    chk("rst_cnt", stall_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
